trace_capture: RTL and testbench

Parametrised on-chip trace capture core: a successor to the vendor JTAG logic analyser used to debug the timing-attack target. It samples a WIDTH-bit probe bus into a circular buffer and triggers on a masked value match. It keeps a programmable number of pre-trigger samples and freezes the buffer when the capture completes. Readout goes through a simple request/valid port, so the MCU bridge or a UART dumper can extract traces without vendor tooling.

---
 rtl/trace_pkg.sv | 14 +
 rtl/trace_ram.sv | 28 ++
 rtl/trace_capture.sv | 145 ++++++++++++++
 tb/tb_trace_capture.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared state encoding for the trace capture core.
package trace_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace buffer, one write and one registered read port, shaped for block RAM.
module trace_ram #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset, which block RAM output latches support.
  always_ff @(posedge clk) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_capture.sv
// Trace capture core: circular probe buffer, masked-match trigger, pre-trigger window, 2-cycle readout.
// Defining TRACE_EDGE_TRIG_EN adds trig_edge_i for per-bit rising-edge triggering.
module trace_capture
  import trace_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   probe_i,
  input  logic               sample_en_i,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic [AW-1:0]      pretrig_i,
  input  logic [WIDTH-1:0]   trig_mask_i,
  input  logic [WIDTH-1:0]   trig_value_i,
`ifdef TRACE_EDGE_TRIG_EN
  input  logic [WIDTH-1:0]   trig_edge_i,
`endif
  input  logic               rd_req_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic               rd_valid_o,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic [STATE_W-1:0] state_o,
  output logic               triggered_o,
  output logic               done_o,
  output logic [AW-1:0]      trig_addr_o
);

  state_t           state;
  logic [AW-1:0]    wr_ptr, cnt, pre_len, post_len, rd_addr_q;
  logic             wr_en, hit, rd_v1, can_arm;
  logic [WIDTH-1:0] bit_ok;

  // An AW-bit pretrig value can never exceed DEPTH-1, so the clamp is implicit.
  assign post_len = ~pre_len;
  assign can_arm  = (state == IDLE) || (state == DONE);
  assign wr_en    = !abort_i && sample_en_i &&
                    ((state == PRE) || (state == WAIT) || (state == POST));

`ifdef TRACE_EDGE_TRIG_EN
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (!rst_n)                            prev <= '0;
    else if (can_arm && arm_i && !abort_i) prev <= '0;
    else if (wr_en)                        prev <= probe_i;
  end

  assign bit_ok = (trig_edge_i & ~prev & probe_i) | (~trig_edge_i & ~(probe_i ^ trig_value_i));
`else
  assign bit_ok = ~(probe_i ^ trig_value_i);
`endif

  assign hit     = sample_en_i && (&(bit_ok | ~trig_mask_i));
  assign state_o = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      cnt         <= '0;
      pre_len     <= '0;
      triggered_o <= 1'b0;
      done_o      <= 1'b0;
      trig_addr_o <= '0;
    end else if (abort_i) begin
      state       <= IDLE;
      triggered_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        IDLE, DONE: begin
          if (arm_i) begin
            pre_len     <= pretrig_i;
            wr_ptr      <= '0;
            cnt         <= '0;
            triggered_o <= 1'b0;
            done_o      <= 1'b0;
            state       <= (pretrig_i == '0) ? WAIT : PRE;
          end
        end
        PRE: begin
          if (sample_en_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == pre_len - 1'b1) begin
              cnt   <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (hit) begin
            triggered_o <= 1'b1;
            trig_addr_o <= wr_ptr;
            cnt         <= '0;
            if (post_len == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (sample_en_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == post_len - 1'b1) begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read pipeline: translate logical index to physical address, then RAM output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v1      <= 1'b0;
      rd_addr_q  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_v1      <= rd_req_i && (state == DONE) && !abort_i;
      rd_addr_q  <= trig_addr_o - pre_len + rd_addr_i;
      rd_valid_o <= rd_v1;
    end
  end

  trace_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (probe_i),
    .raddr (rd_addr_q),
    .rdata (rd_data_o)
  );

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture at WIDTH=8, DEPTH=16 against a sample-log reference model.
module tb_trace_capture;

  logic       clk, rst_n;
  logic [7:0] probe, mask, value, edge_m;
  logic       sample_en, arm, abort, rd_req;
  logic [3:0] pretrig, rd_addr;
  logic       rd_valid_o, triggered_o, done_o;
  logic [7:0] rd_data_o;
  logic [2:0] state_o;
  logic [3:0] trig_addr_o;

  int tests_run = 0;
  int fails = 0;

  // Model state: every sample the capture should have stored, in order since arm.
  logic [7:0] log_q[$];
  int t, t_cycle, last_c, got_done, got_trig;
  logic [3:0] got_taddr;
  logic [7:0] rd_got[16];
  int rd_cnt;

  trace_capture #(.WIDTH(8), .DEPTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .probe_i      (probe),
    .sample_en_i  (sample_en),
    .arm_i        (arm),
    .abort_i      (abort),
    .pretrig_i    (pretrig),
    .trig_mask_i  (mask),
    .trig_value_i (value),
`ifdef TRACE_EDGE_TRIG_EN
    .trig_edge_i  (edge_m),
`endif
    .rd_req_i     (rd_req),
    .rd_addr_i    (rd_addr),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_data_o),
    .state_o      (state_o),
    .triggered_o  (triggered_o),
    .done_o       (done_o),
    .trig_addr_o  (trig_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_match(input logic [7:0] cur, input logic [7:0] prv,
                                     input logic [7:0] m, input logic [7:0] v, input logic [7:0] e);
    bit ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (m[b]) begin
        if (e[b]) ok &= (!prv[b] && cur[b]);
        else      ok &= (cur[b] == v[b]);
      end
    end
    return ok;
  endfunction

  // Arms and feeds probe samples until done_o is seen, logging expected stores and trigger point.
  task automatic capture(input int p, input logic [7:0] m, input logic [7:0] v,
                         input int mode, input int period);
    log_q.delete();
    t = -1; t_cycle = -1; last_c = -1; got_done = -1; got_trig = -1;
    mask = m; value = v; pretrig = p[3:0]; sample_en = 1'b0;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (triggered_o && got_trig < 0) got_trig = c;
      if (done_o) begin
        got_done = c;
        got_taddr = trig_addr_o;
        break;
      end
      case (mode)
        0:       probe = c[7:0];
        1:       probe = 8'($urandom);
        default: probe = {c[6:0], (c != 6)};
      endcase
      sample_en = (period == 0) ? 1'($urandom_range(0, 1)) : ((c % period) == 0);
      if (sample_en) begin
        logic [7:0] pv;
        pv = (log_q.size() == 0) ? 8'h00 : log_q[log_q.size()-1];
        if (t < 0 && log_q.size() >= p && model_match(probe, pv, m, v, edge_m)) begin
          t = log_q.size();
          t_cycle = c;
        end
        log_q.push_back(probe);
        if (t >= 0 && log_q.size() == t + 16 - p) last_c = c;
      end
      @(negedge clk);
    end
    sample_en = 1'b0;
    if (got_done < 0) begin
      tests_run++; fails++;
      $display("FAIL capture_timeout: done_o never rose (p=%0d mask=%h value=%h)", p, m, v);
    end
  endtask

  // Issues 16 back-to-back reads and collects whatever returns, aligned to the 2-cycle latency.
  task automatic readout();
    rd_cnt = 0;
    for (int a = 0; a < 16; a++) rd_got[a] = 'x;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid_o) begin
        if (i >= 2 && i < 18) rd_got[i-2] = rd_data_o;
        rd_cnt++;
      end
      rd_req = (i < 16);
      rd_addr = i[3:0];
      @(negedge clk);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (state_o !== 3'd0)     begin fails++; $display("FAIL reset_state: got %0d want 0", state_o); end
    tests_run++; if (done_o !== 1'b0)      begin fails++; $display("FAIL reset_done: got %b want 0", done_o); end
    tests_run++; if (triggered_o !== 1'b0) begin fails++; $display("FAIL reset_trig: got %b want 0", triggered_o); end
    tests_run++; if (trig_addr_o !== 4'd0) begin fails++; $display("FAIL reset_taddr: got %0d want 0", trig_addr_o); end
    tests_run++; if (rd_valid_o !== 1'b0)  begin fails++; $display("FAIL reset_rdvalid: got %b want 0", rd_valid_o); end
    tests_run++; if (rd_data_o !== 8'h00)  begin fails++; $display("FAIL reset_rddata: got %h want 00", rd_data_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    capture(4, 8'hFF, 8'h09, 0, 1);
    tests_run++; if (got_trig !== 10)      begin fails++; $display("FAIL basic_trig_time: got %0d want 10", got_trig); end
    tests_run++; if (got_taddr !== 4'd9)   begin fails++; $display("FAIL basic_taddr: got %0d want 9", got_taddr); end
    tests_run++; if (got_done !== 21)      begin fails++; $display("FAIL basic_done_time: got %0d want 21", got_done); end
    tests_run++; if (state_o !== 3'd4)     begin fails++; $display("FAIL basic_state: got %0d want 4", state_o); end
    readout();
    for (int a = 0; a < 16; a++) begin
      tests_run++;
      if (rd_got[a] !== 8'(5 + a)) begin fails++; $display("FAIL basic_read[%0d]: got %h want %h", a, rd_got[a], 8'(5 + a)); end
    end
  endtask

  task automatic test_mask0_p0();
    capture(0, 8'h00, 8'h5A, 1, 1);
    tests_run++; if (got_taddr !== 4'd0) begin fails++; $display("FAIL m0_taddr: got %0d want 0", got_taddr); end
    tests_run++; if (got_done !== 16)    begin fails++; $display("FAIL m0_done_time: got %0d want 16", got_done); end
    readout();
    for (int a = 0; a < 16; a++) begin
      tests_run++;
      if (rd_got[a] !== log_q[a]) begin fails++; $display("FAIL m0_read[%0d]: got %h want %h", a, rd_got[a], log_q[a]); end
    end
  endtask

  task automatic test_p_max();
    capture(15, 8'hFF, 8'h0F, 0, 1);
    tests_run++; if (got_trig !== 16)     begin fails++; $display("FAIL pmax_trig_time: got %0d want 16", got_trig); end
    tests_run++; if (got_done !== 16)     begin fails++; $display("FAIL pmax_done_time: got %0d want 16", got_done); end
    tests_run++; if (got_taddr !== 4'd15) begin fails++; $display("FAIL pmax_taddr: got %0d want 15", got_taddr); end
    readout();
    tests_run++; if (rd_got[15] !== 8'h0F) begin fails++; $display("FAIL pmax_read15: got %h want 0f", rd_got[15]); end
    tests_run++; if (rd_got[0] !== 8'h00)  begin fails++; $display("FAIL pmax_read0: got %h want 00", rd_got[0]); end
  endtask

  task automatic test_strobe();
    capture(2, 8'hFF, 8'h0A, 0, 3);
    if (got_done >= 0) begin
      tests_run++; if (got_trig !== t_cycle + 1) begin fails++; $display("FAIL strobe_trig_time: got %0d want %0d", got_trig, t_cycle + 1); end
      tests_run++; if (got_done !== last_c + 1)  begin fails++; $display("FAIL strobe_done_time: got %0d want %0d", got_done, last_c + 1); end
      tests_run++; if (got_taddr !== 4'(t))      begin fails++; $display("FAIL strobe_taddr: got %0d want %0d", got_taddr, 4'(t)); end
      readout();
      tests_run++; if (rd_got[2] !== 8'h0A) begin fails++; $display("FAIL strobe_trig_sample: got %h want 0a", rd_got[2]); end
      for (int a = 0; a < 16; a++) begin
        tests_run++;
        if (rd_got[a] !== log_q[t-2+a]) begin fails++; $display("FAIL strobe_read[%0d]: got %h want %h", a, rd_got[a], log_q[t-2+a]); end
      end
    end
  endtask

  task automatic test_abort();
    int vcnt;
    probe = 8'h00; mask = 8'hFF; value = 8'hEE; pretrig = 4'd3; sample_en = 1'b1;
    arm = 1'b1; @(negedge clk); arm = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++; if (state_o !== 3'd2) begin fails++; $display("FAIL abort_pre_state: got %0d want 2", state_o); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    tests_run++; if (state_o !== 3'd0)     begin fails++; $display("FAIL abort_state: got %0d want 0", state_o); end
    tests_run++; if (triggered_o !== 1'b0) begin fails++; $display("FAIL abort_trig: got %b want 0", triggered_o); end
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_valid_o) vcnt++;
      rd_req = (i < 4); rd_addr = i[3:0];
      @(negedge clk);
    end
    rd_req = 1'b0;
    tests_run++; if (vcnt !== 0) begin fails++; $display("FAIL abort_read_ignored: got %0d valids want 0", vcnt); end
    mask = 8'h00; pretrig = 4'd0;
    arm = 1'b1; @(negedge clk); arm = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (triggered_o !== 1'b1) begin fails++; $display("FAIL abort_post_trig_set: got %b want 1", triggered_o); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    tests_run++; if (triggered_o !== 1'b0) begin fails++; $display("FAIL abort_post_trig_clr: got %b want 0", triggered_o); end
    sample_en = 1'b0;
    capture(4, 8'hFF, 8'h09, 0, 1);
    readout();
    for (int a = 0; a < 16; a++) begin
      tests_run++;
      if (rd_got[a] !== 8'(5 + a)) begin fails++; $display("FAIL rearm_read[%0d]: got %h want %h", a, rd_got[a], 8'(5 + a)); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int p;
      logic [7:0] m;
      p = $urandom_range(0, 15);
      m = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
      capture(p, m, 8'($urandom), 1, 0);
      if (got_done >= 0 && t >= 0) begin
        tests_run++; if (got_trig !== t_cycle + 1) begin fails++; $display("FAIL rnd%0d_trig_time: got %0d want %0d", it, got_trig, t_cycle + 1); end
        tests_run++; if (got_done !== last_c + 1)  begin fails++; $display("FAIL rnd%0d_done_time: got %0d want %0d", it, got_done, last_c + 1); end
        tests_run++; if (got_taddr !== 4'(t))      begin fails++; $display("FAIL rnd%0d_taddr: got %0d want %0d", it, got_taddr, 4'(t)); end
        readout();
        for (int a = 0; a < 16; a++) begin
          tests_run++;
          if (rd_got[a] !== log_q[t-p+a]) begin fails++; $display("FAIL rnd%0d_read[%0d]: got %h want %h", it, a, rd_got[a], log_q[t-p+a]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    capture(6, 8'h00, 8'h00, 1, 1);
    readout();
    tests_run++; if (rd_cnt !== 16) begin fails++; $display("FAIL b2b_valid_count: got %0d want 16", rd_cnt); end
    for (int a = 0; a < 16; a++) begin
      tests_run++;
      if (rd_got[a] !== log_q[a]) begin fails++; $display("FAIL b2b_read[%0d]: got %h want %h", a, rd_got[a], log_q[a]); end
    end
  endtask

`ifdef TRACE_EDGE_TRIG_EN
  task automatic test_edge();
    edge_m = 8'h01;
    probe = 8'h01;
    @(negedge clk);
    capture(2, 8'h01, 8'h00, 2, 1);
    tests_run++; if (got_trig !== 8)     begin fails++; $display("FAIL edge_trig_time: got %0d want 8", got_trig); end
    tests_run++; if (got_taddr !== 4'd7) begin fails++; $display("FAIL edge_taddr: got %0d want 7", got_taddr); end
    readout();
    tests_run++; if (rd_got[2] !== 8'h0F) begin fails++; $display("FAIL edge_trig_sample: got %h want 0f", rd_got[2]); end
    edge_m = 8'h00;
  endtask
`endif

  initial begin
    rst_n = 1'b0; probe = 8'h00; sample_en = 1'b0; arm = 1'b0; abort = 1'b0;
    pretrig = 4'd0; mask = 8'h00; value = 8'h00; edge_m = 8'h00;
    rd_req = 1'b0; rd_addr = 4'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_mask0_p0();
    test_p_max();
    test_strobe();
    test_abort();
    test_random();
    test_back_to_back();
`ifdef TRACE_EDGE_TRIG_EN
    test_edge();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
